// File: rtl/hierarchical_scope_pkg.sv
// Shared types and helpers for the hierarchical scoped-lookup pipeline.
package hierarchical_scope_pkg;

    // Per-transaction combine mode.
    typedef enum logic {
        MODE_LEGACY = 1'b0,
        MODE_ACCUM  = 1'b1
    } mode_e;

    // Width of the output handshake counter.
    localparam int COUNT_W = 16;

    // Advance the handshake counter by one when a handshake happens.
    // The counter wraps silently from all-ones to zero.
    function automatic logic [COUNT_W-1:0] count_next(
        input logic [COUNT_W-1:0] count,
        input logic               hs
    );
        logic [COUNT_W-1:0] step;
        step = {{(COUNT_W-1){1'b0}}, hs};
        return count + step;
    endfunction

    // Modulo-2^w sum of two 32-bit-held operands, masked to the data width.
    // Used only where a width-agnostic wrap is clearer than a sized add.
    function automatic logic [31:0] wrap_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned w
    );
        logic [31:0] mask;
        if (w >= 32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << w) - 32'd1;
        end
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/hierarchical_scope_acc_bank.sv
// Per-channel accumulator bank: combinational read port, one write port,
// and a bank-wide clear that a same-cycle write overrides on its channel.
module hierarchical_scope_acc_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CH_W-1:0]  rd_chan,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_chan,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] acc_q [CHANNELS];
    logic [WIDTH-1:0] acc_d [CHANNELS];

    // Read port: a clear in this cycle makes every channel read as zero, so a
    // transfer colliding with clr combines with 0 instead of the stale value.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (!clr && (rd_chan == CH_W'(i))) begin
                rd_data = acc_q[i];
            end else begin
                rd_data = rd_data;
            end
        end
    end

    // Next-state: a write wins on its own channel, clr zeroes the rest.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_chan == CH_W'(i))) begin
                acc_d[i] = wr_data;
            end else if (clr) begin
                acc_d[i] = {WIDTH{1'b0}};
            end else begin
                acc_d[i] = acc_q[i];
            end
        end
    end

    // Accumulator storage with synchronous reset.
    always_ff @(posedge clk) begin : acc_store
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                acc_q[i] <= {WIDTH{1'b0}};
            end else begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: rtl/hierarchical_scope_pipe.sv
// Two-stage scoped-lookup pipeline. S1 (outer scope) captures the operand
// and its scoped middle value; S2 (inner scope) combines middle with either
// the operand (legacy) or a per-channel accumulator (accumulate), reading
// the S1 locals by hierarchical name.
module hierarchical_scope_pipe
    import hierarchical_scope_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int INCR     = 1,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH_W-1:0]    in_chan,
    input  logic               in_mode,
    input  logic [WIDTH-1:0]   in_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_chan,
    output logic [WIDTH-1:0]   out_val,
    output logic [COUNT_W-1:0] out_count
);

    localparam logic [WIDTH-1:0] INCR_W   = WIDTH'(INCR);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  chan;
        mode_e            mode;
        logic [WIDTH-1:0] in_val;
        logic [WIDTH-1:0] middle;
    } s1_t;

    logic             s1_adv_s;
    logic             s2_adv_s;
    logic             xfer_s;
    logic             acc_wr_en_s;
    logic [WIDTH-1:0] acc_rd_s;
    logic [CH_W-1:0]  chan_map_s;

    // Channels beyond the populated range fold onto channel 0.
    if (CHANNELS == (1 << CH_W)) begin : g_chan_full
        assign chan_map_s = in_chan;
    end else begin : g_chan_clip
        assign chan_map_s = ({1'b0, in_chan} < CH_LIMIT) ? in_chan : {CH_W{1'b0}};
    end

    // Stage advance chain: S2 frees when empty or drained, S1 follows S2.
    assign s2_adv_s = !s2_scope.out_valid_q || out_ready;
    assign s1_adv_s = !s1_scope.s1_q.valid || s2_adv_s;
    assign in_ready = s1_adv_s;
    assign xfer_s   = s1_scope.s1_q.valid && s2_adv_s;

    // -----------------------------------------------------------------
    // S1: outer scope. Holds the accepted operand and its middle value.
    // -----------------------------------------------------------------
    if (1'b1) begin : s1_scope
        s1_t s1_d;
        s1_t s1_q;

        // Load on advance; otherwise hold so a stalled entry stays intact.
        always_comb begin
            s1_d = s1_q;
            if (s1_adv_s) begin
                s1_d.valid = in_valid;
                if (in_valid) begin
                    s1_d.chan   = chan_map_s;
                    s1_d.mode   = mode_e'(in_mode);
                    s1_d.in_val = in_val;
                    s1_d.middle = in_val + INCR_W;
                end else begin
                    s1_d.chan   = s1_q.chan;
                    s1_d.mode   = s1_q.mode;
                    s1_d.in_val = s1_q.in_val;
                    s1_d.middle = s1_q.middle;
                end
            end else begin
                s1_d = s1_q;
            end
        end

        // S1 register bank.
        always_ff @(posedge clk) begin : s1_stage
            if (rst) begin
                s1_q <= {$bits(s1_t){1'b0}};
            end else begin
                s1_q <= s1_d;
            end
        end
    end

    // -----------------------------------------------------------------
    // S2: inner scope. Combines S1 locals and owns the output registers.
    // -----------------------------------------------------------------
    if (1'b1) begin : s2_scope
        logic               out_valid_d;
        logic               out_valid_q;
        logic [CH_W-1:0]    out_chan_d;
        logic [CH_W-1:0]    out_chan_q;
        logic [WIDTH-1:0]   out_val_d;
        logic [WIDTH-1:0]   out_val_q;
        logic [COUNT_W-1:0] count_d;
        logic [COUNT_W-1:0] count_q;
        logic [WIDTH-1:0]   result_s;

        // Combine middle with the operand or the channel accumulator.
        always_comb begin
            case (s1_scope.s1_q.mode)
                MODE_LEGACY: result_s = s1_scope.s1_q.in_val + s1_scope.s1_q.middle;
                MODE_ACCUM:  result_s = acc_rd_s + s1_scope.s1_q.middle;
                default:     result_s = s1_scope.s1_q.in_val + s1_scope.s1_q.middle;
            endcase
        end

        // Output next-state: refill on advance, hold while back-pressured.
        always_comb begin
            out_valid_d = out_valid_q;
            out_chan_d  = out_chan_q;
            out_val_d   = out_val_q;
            if (s2_adv_s) begin
                out_valid_d = s1_scope.s1_q.valid;
                if (s1_scope.s1_q.valid) begin
                    out_chan_d = s1_scope.s1_q.chan;
                    out_val_d  = result_s;
                end else begin
                    out_chan_d = out_chan_q;
                    out_val_d  = out_val_q;
                end
            end else begin
                out_valid_d = out_valid_q;
            end
            count_d = count_next(count_q, out_valid_q && out_ready);
        end

        // S2 output registers and handshake counter.
        always_ff @(posedge clk) begin : s2_stage
            if (rst) begin
                out_valid_q <= 1'b0;
                out_chan_q  <= {CH_W{1'b0}};
                out_val_q   <= {WIDTH{1'b0}};
                count_q     <= {COUNT_W{1'b0}};
            end else begin
                out_valid_q <= out_valid_d;
                out_chan_q  <= out_chan_d;
                out_val_q   <= out_val_d;
                count_q     <= count_d;
            end
        end
    end

    // Accumulators update exactly once per S1->S2 transfer in accumulate mode.
    assign acc_wr_en_s = xfer_s && (s1_scope.s1_q.mode == MODE_ACCUM);

    hierarchical_scope_acc_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_acc_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .rd_chan (s1_scope.s1_q.chan),
        .rd_data (acc_rd_s),
        .wr_en   (acc_wr_en_s),
        .wr_chan (s1_scope.s1_q.chan),
        .wr_data (s2_scope.result_s)
    );

    assign out_valid = s2_scope.out_valid_q;
    assign out_chan  = s2_scope.out_chan_q;
    assign out_val   = s2_scope.out_val_q;
    assign out_count = s2_scope.count_q;

endmodule

// File: tb/tb_hierarchical_scope_pipe.sv
// Self-checking bench for hierarchical_scope_pipe: directed scenarios plus a
// randomized phase, all scored against a transaction-level reference model.
module tb_hierarchical_scope_pipe;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int INCR     = 1;
    localparam int CH_W     = 2;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_chan;
    logic             in_mode;
    logic [WIDTH-1:0] in_val;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_chan;
    logic [WIDTH-1:0] out_val;
    logic [15:0]      out_count;

    typedef struct {
        logic [WIDTH-1:0] val;
        logic [CH_W-1:0]  chan;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_m [CHANNELS];
    logic [15:0] cnt_m;
    int unsigned accept_cnt;
    int unsigned n_assert;
    int unsigned n_fail;

    hierarchical_scope_pipe #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .INCR     (INCR),
        .CH_W     (CH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_chan   (in_chan),
        .in_mode   (in_mode),
        .in_val    (in_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_val   (out_val),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: result of one accepted transaction, in plain arithmetic.
    task automatic model_accept(input logic [CH_W-1:0] ch, input logic md, input logic [WIDTH-1:0] v);
        int r;
        exp_t e;
        if (md == 1'b0) begin
            r = (2 * int'(v) + INCR) % 256;
        end else begin
            r = (acc_m[ch] + int'(v) + INCR) % 256;
            acc_m[ch] = r;
        end
        e.val  = r[WIDTH-1:0];
        e.chan = ch;
        exp_q.push_back(e);
    endtask

    task automatic model_clear_acc();
        for (int i = 0; i < CHANNELS; i++) acc_m[i] = 0;
    endtask

    // Monitor: score outputs, count handshakes, log accepts, away from posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_clear_acc();
            cnt_m = 16'd0;
        end else begin
            check_val("out_count", {16'd0, out_count}, {16'd0, cnt_m});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", 32'd1, 32'd0);
                end else begin
                    check_val("out_val", {24'd0, out_val}, {24'd0, exp_q[0].val});
                    check_val("out_chan", {30'd0, out_chan}, {30'd0, exp_q[0].chan});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        cnt_m = cnt_m + 16'd1;
                    end
                end
            end
            if (clr) model_clear_acc();
            if (in_valid && in_ready) begin
                model_accept(in_chan, in_mode, in_val);
                accept_cnt++;
            end
        end
    end

    // Present one transaction and hold it until accepted (bounded).
    task automatic send(input logic [CH_W-1:0] ch, input logic md, input logic [WIDTH-1:0] v);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_chan  = ch;
        in_mode  = md;
        in_val   = v;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("send_accepted", {31'd0, ok}, 32'd1);
    endtask

    // Let every expected result leave the pipe (bounded).
    task automatic drain();
        bit ok;
        ok        = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("drain_done", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a0;
        n_assert   = 0;
        n_fail     = 0;
        accept_cnt = 0;
        cnt_m      = 16'd0;
        model_clear_acc();
        rst        = 1'b1;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_chan    = 2'd0;
        in_mode    = 1'b0;
        in_val     = 8'd0;
        out_ready  = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_val", {24'd0, out_val}, 32'd0);
        check_val("rst_out_chan", {30'd0, out_chan}, 32'd0);
        check_val("rst_out_count", {16'd0, out_count}, 32'd0);
        @(posedge clk);
        #1;

        // Legacy basic with latency check: 5 -> 11.
        send(2'd0, 1'b0, 8'd5);
        @(negedge clk);
        check_val("latency_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_val("latency_c2", {31'd0, out_valid}, 32'd1);
        check_val("legacy_5", {24'd0, out_val}, 32'd11);
        drain();
        check_val("count_after_basic", {16'd0, out_count}, 32'd1);

        // Legacy wrap: 200 -> 145, 255 -> 255.
        send(2'd1, 1'b0, 8'd200);
        send(2'd3, 1'b0, 8'hFF);
        drain();

        // Accumulate: channel 2 3,4 -> 4,9; channel 1 10 -> 11; channel 2 untouched.
        send(2'd2, 1'b1, 8'd3);
        send(2'd2, 1'b1, 8'd4);
        send(2'd1, 1'b1, 8'd10);
        send(2'd2, 1'b1, 8'd0);
        drain();

        // Backpressure: 4 cycles of offered input, only 2 accepted.
        out_ready = 1'b0;
        a0 = accept_cnt;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_chan  = 2'd3;
            in_mode  = 1'b0;
            in_val   = 8'(7 + i);
            @(posedge clk);
            #1;
        end
        check_val("bp_accepts", accept_cnt - a0, 32'd2);
        check_val("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drain();
        check_val("bp_in_ready_high", {31'd0, in_ready}, 32'd1);

        // Clear collision: channel 0 to 20, then clr during transfer of 6.
        send(2'd0, 1'b1, 8'd19);
        drain();
        in_valid = 1'b1;
        in_chan  = 2'd0;
        in_mode  = 1'b1;
        in_val   = 8'd6;
        @(negedge clk);
        check_val("clr_setup_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        // Transfer saw a cleared bank: result is middle alone.
        exp_q[0] = '{val: 8'd7, chan: 2'd0};
        model_clear_acc();
        acc_m[0] = 7;
        drain();
        for (int c = 0; c < CHANNELS; c++) send(2'(c), 1'b1, 8'd0);
        drain();

        // Randomized traffic, no clr.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_chan   = 2'($urandom_range(0, 3));
            in_mode   = 1'($urandom_range(0, 1));
            in_val    = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-flight: two in the pipe, then a one-cycle reset.
        out_ready = 1'b0;
        send(2'd1, 1'b1, 8'd50);
        send(2'd2, 1'b0, 8'd60);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("midrst_count", {16'd0, out_count}, 32'd0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(2'd1, 1'b1, 8'd2);
        drain();
        check_val("final_count", {16'd0, out_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
